// File: rtl/fpga_reset_sequencer_if.sv
// Board reset sequencer signal bundle: raw asynchronous inputs from the
// board and the sequenced, registered reset/power controls going out.
interface fpga_reset_sequencer_if;
   logic       btn_rst_ni;
   logic       pll_locked_i;
   logic       sd_pwr_n_o;
   logic       soc_rst_no;
   logic       jtag_trst_no;
   logic       busy_o;
   logic [2:0] state_o;

   // Sequencer side: samples the raw inputs, drives the controls
   modport slave (
      input  btn_rst_ni,
      input  pll_locked_i,
      output sd_pwr_n_o,
      output soc_rst_no,
      output jtag_trst_no,
      output busy_o,
      output state_o
   );

   // Board/bench side: drives the raw inputs, observes the controls
   modport master (
      output btn_rst_ni,
      output pll_locked_i,
      input  sd_pwr_n_o,
      input  soc_rst_no,
      input  jtag_trst_no,
      input  busy_o,
      input  state_o
   );
endinterface

// File: rtl/fpga_reset_sequencer.sv
// Board-level reset/power-up sequencer. Synchronises and debounces the reset
// button and the PLL lock flag, then powers the SD card, holds the SoC in
// reset for a while and finally releases SoC reset and JTAG TRST together.
// Losing lock or pressing the button restarts the whole sequence, which also
// power-cycles the SD card.
module fpga_reset_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned SD_PWR_CYCLES   = 1024,
   parameter int unsigned SOC_HOLD_CYCLES = 256,
   parameter int unsigned CNT_W           = 20
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   fpga_reset_sequencer_if.slave       io
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SD_PWR    = 2'd1,
      SOC_HOLD  = 2'd2,
      RUN       = 2'd3
   } state_e;

   // Counters are compared at their final value, so they never wrap
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SD_LAST  = CNT_W'(SD_PWR_CYCLES - 1);
   localparam logic [CNT_W-1:0] SOC_LAST = CNT_W'(SOC_HOLD_CYCLES - 1);

   logic             btn_meta_q, btn_s_q;
   logic             lock_meta_q, lock_s_q;
   logic             btn_db_q;
   logic [CNT_W-1:0] dcnt_q;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sd_pwr_n_q, soc_rst_n_q, jtag_trst_n_q, busy_q;
   logic             seq_ok;

   // Two-flop synchronisers; button idles released (1), lock idles unlocked (0)
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         btn_meta_q  <= 1'b1;
         btn_s_q     <= 1'b1;
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         btn_meta_q  <= io.btn_rst_ni;
         btn_s_q     <= btn_meta_q;
         lock_meta_q <= io.pll_locked_i;
         lock_s_q    <= lock_meta_q;
      end
   end

   // Debounce: accept a new button level only after it differs for DEBOUNCE_CYCLES edges in a row
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         btn_db_q <= 1'b1;
         dcnt_q   <= '0;
      end else if (btn_s_q == btn_db_q) begin
         dcnt_q   <= '0;
      end else if (dcnt_q == DB_LAST) begin
         btn_db_q <= btn_s_q;
         dcnt_q   <= '0;
      end else begin
         dcnt_q   <= dcnt_q + 1'b1;
      end
   end

   // Sequencing may proceed only while locked and the button is released
   assign seq_ok = lock_s_q & btn_db_q;

   // Next-state logic; an abort outranks a dwell counter finishing on the same cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         WAIT_LOCK: begin
            if (seq_ok) begin
               state_d = SD_PWR;
               cnt_d   = '0;
            end
         end
         SD_PWR: begin
            if (!seq_ok) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == SD_LAST) begin
               state_d = SOC_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         SOC_HOLD: begin
            if (!seq_ok) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == SOC_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!seq_ok) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
   end

   // State and outputs share one edge; outputs decode the next state so they are glitch-free registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= WAIT_LOCK;
         cnt_q         <= '0;
         sd_pwr_n_q    <= 1'b1;
         soc_rst_n_q   <= 1'b0;
         jtag_trst_n_q <= 1'b0;
         busy_q        <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sd_pwr_n_q    <= (state_d == WAIT_LOCK);
         soc_rst_n_q   <= (state_d == RUN);
         jtag_trst_n_q <= (state_d == RUN);
         busy_q        <= (state_d != RUN);
      end
   end

   assign io.sd_pwr_n_o   = sd_pwr_n_q;
   assign io.soc_rst_no   = soc_rst_n_q;
   assign io.jtag_trst_no = jtag_trst_n_q;
   assign io.busy_o       = busy_q;
   assign io.state_o      = {1'b0, state_q};

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Bench for fpga_reset_sequencer with short dwell times. A stimulus process
// drives the raw inputs each cycle and pushes the expected outputs from a
// behavioural model; a monitor pops and compares after every clock edge.
module tb_fpga_reset_sequencer;
   localparam int DB  = 4;
   localparam int SD  = 8;
   localparam int SOC = 4;

   localparam logic [6:0] O_WAIT = 7'b000_1_0_0_1;
   localparam logic [6:0] O_SD   = 7'b001_1_0_0_0;
   localparam logic [6:0] O_SOC  = 7'b010_1_0_0_0;
   localparam logic [6:0] O_RUN  = 7'b011_0_1_1_0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   fpga_reset_sequencer_if bus ();

   fpga_reset_sequencer #(
      .DEBOUNCE_CYCLES(DB),
      .SD_PWR_CYCLES  (SD),
      .SOC_HOLD_CYCLES(SOC),
      .CNT_W          (20)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .io    (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cycle_no = 0;
   bit run = 1'b0;
   logic [6:0] exp_q[$];

   // Behavioural model: sync chains as delay taps, debounce as a mismatch
   // run length, sequence as the age (cycles) since power-up started.
   int m_bs1 = 1, m_bs2 = 1, m_ls1 = 0, m_ls2 = 0;
   int m_db = 1, m_mism = 0, m_age = -1;

   function automatic logic [6:0] dut_out();
      return {bus.state_o, bus.busy_o, bus.jtag_trst_no, bus.soc_rst_no, bus.sd_pwr_n_o};
   endfunction

   function automatic logic [6:0] model_out();
      if (m_age < 0)             return O_WAIT;
      else if (m_age < SD)       return O_SD;
      else if (m_age < SD + SOC) return O_SOC;
      else                       return O_RUN;
   endfunction

   task automatic model_edge(input bit b, input bit l, input bit r);
      bit ok;
      if (!r) begin
         m_bs1 = 1; m_bs2 = 1; m_ls1 = 0; m_ls2 = 0;
         m_db = 1; m_mism = 0; m_age = -1;
      end else begin
         ok = (m_ls2 != 0) && (m_db != 0);
         if (m_age >= 0 && !ok)              m_age = -1;
         else if (m_age < 0 && ok)           m_age = 0;
         else if (m_age >= 0 && m_age < SD + SOC) m_age++;
         if (m_bs2 != m_db) begin
            m_mism++;
            if (m_mism == DB) begin
               m_db = m_bs2;
               m_mism = 0;
            end
         end else begin
            m_mism = 0;
         end
         m_bs2 = m_bs1; m_bs1 = b;
         m_ls2 = m_ls1; m_ls1 = l;
      end
   endtask

   // One clock cycle of stimulus; the expectation is for the following rising edge
   task automatic cyc(input bit b, input bit l, input bit r);
      @(negedge clk);
      bus.btn_rst_ni   = b;
      bus.pll_locked_i = l;
      rst_n            = r;
      model_edge(b, l, r);
      exp_q.push_back(model_out());
      run = 1'b1;
   endtask

   task automatic cycn(input int n, input bit b, input bit l, input bit r);
      for (int i = 0; i < n; i++) cyc(b, l, r);
   endtask

   // Fixed timing anchors taken directly from the expected sequence timing
   task automatic anchor(input string name, input logic [6:0] expv);
      @(posedge clk);
      #2;
      checks++;
      if (dut_out() !== expv) begin
         failures++;
         $display("FAIL %s: got %b required %b", name, dut_out(), expv);
      end
   endtask

   // Monitor: one expected output word per clock edge while stimulus is running
   initial begin
      logic [6:0] e;
      forever begin
         @(posedge clk);
         #1;
         cycle_no++;
         if (run) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL scoreboard_empty cycle %0d: got %b required an expectation", cycle_no, dut_out());
            end else begin
               e = exp_q.pop_front();
               if (dut_out() !== e) begin
                  failures++;
                  $display("FAIL scoreboard cycle %0d: got %b required %b", cycle_no, dut_out(), e);
               end
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not reach the end of stimulus");
      $fatal(1, "timeout");
   end

   initial begin
      bit b, l, r;
      int len;
      bus.btn_rst_ni   = 1'b1;
      bus.pll_locked_i = 1'b1;

      // Reset
      cycn(3, 1, 1, 0);
      anchor("reset_state", O_WAIT);

      // Power-up timing
      cycn(2, 1, 1, 1);
      anchor("pwrup_edge2_wait", O_WAIT);
      cyc(1, 1, 1);
      anchor("pwrup_edge3_sd", O_SD);
      cycn(7, 1, 1, 1);
      anchor("pwrup_edge10_sd", O_SD);
      cyc(1, 1, 1);
      anchor("pwrup_edge11_soc", O_SOC);
      cycn(3, 1, 1, 1);
      anchor("pwrup_edge14_soc", O_SOC);
      cyc(1, 1, 1);
      anchor("pwrup_edge15_run", O_RUN);
      cycn(5, 1, 1, 1);

      // Short button glitch is ignored
      cycn(3, 0, 1, 1);
      cycn(8, 1, 1, 1);
      anchor("glitch_ignored", O_RUN);

      // Long press aborts at edge 7, release reruns to RUN at edge 19
      cycn(6, 0, 1, 1);
      anchor("press_edge6_run", O_RUN);
      cyc(0, 1, 1);
      anchor("press_edge7_abort", O_WAIT);
      cycn(3, 0, 1, 1);
      cycn(18, 1, 1, 1);
      anchor("release_edge18_soc", O_SOC);
      cyc(1, 1, 1);
      anchor("release_edge19_run", O_RUN);

      // Lock lost exactly when SOC_HOLD finishes: abort wins
      cycn(3, 1, 0, 1);
      anchor("unlock_abort", O_WAIT);
      cycn(12, 1, 1, 1);
      cyc(1, 0, 1);
      anchor("holddone_edge13_soc", O_SOC);
      cyc(1, 0, 1);
      anchor("holddone_edge14_soc", O_SOC);
      cyc(1, 0, 1);
      anchor("holddone_abort_wins", O_WAIT);
      cycn(14, 1, 1, 1);
      anchor("relock_edge29_soc", O_SOC);
      cyc(1, 1, 1);
      anchor("relock_edge30_run", O_RUN);

      // Reset pulse mid SD_PWR resets everything, including synchronisers
      cycn(3, 1, 0, 1);
      cycn(5, 1, 1, 1);
      cyc(1, 1, 0);
      anchor("rst_mid_sd", O_WAIT);
      cycn(2, 1, 1, 1);
      anchor("rst_chain_edge2", O_WAIT);
      cyc(1, 1, 1);
      anchor("rst_chain_edge3_sd", O_SD);

      // No lock for 100 cycles
      cycn(100, 1, 0, 1);
      anchor("no_lock_wait", O_WAIT);

      // Randomised segments of held input levels
      for (int s = 0; s < 160; s++) begin
         b   = ($urandom_range(0, 9) < 8);
         l   = ($urandom_range(0, 9) < 8);
         r   = ($urandom_range(0, 29) != 0);
         len = $urandom_range(1, 20);
         for (int k = 0; k < len; k++) cyc(b, l, (k == 0) ? r : 1'b1);
      end

      @(posedge clk);
      #2;
      run = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
